// File: rtl/bin_to_bcd_pkg.sv
// Shared constants and helpers for the sequential binary-to-BCD converter.
// Holds the FSM encoding, a counter-width helper and a digit-count helper.
package bin_to_bcd_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Never returns less than 1 so a w=1 converter still gets a counter bit.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Decimal digits needed for 2**w-1, i.e. ceil(w*log10(2)).
    function automatic int min_digits(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake plus result bundle for bin_to_bcd_seq.
// master: start, bin out; slave: busy, done, bcd, blank, overflow out.
interface bin_to_bcd_seq_if #(
    parameter int w      = 16,
    parameter int digits = 5
);
    logic                  start;
    logic [w-1:0]          bin;
    logic                  busy;
    logic                  done;
    logic [4*digits-1:0]   bcd;
    logic [digits-1:0]     blank;
    logic                  overflow;

    modport master (
        output start, bin,
        input  busy, done, bcd, blank, overflow
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, blank, overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq_bcd_adjust.sv
// Double-dabble nibble correction: adds 3 when the digit is 5 or more.
// Ports: nib_i digit in, nib_o corrected digit out.
module bcd_adjust (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);
    assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter, one input bit per clock.
// Ports: clk, reset (sync, active high), bus (slave handshake/result).
module bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
#(
    parameter int w      = 16,
    parameter int digits = 5
) (
    input  logic             clk,
    input  logic             reset,
    bin_to_bcd_seq_if.slave  bus
);
    localparam int CW = clog2(w);
    localparam int SW = 4 * digits;
    localparam logic [CW-1:0] LAST = CW'(w - 1);
    localparam bit OVF_POSSIBLE = (digits < min_digits(w));
    localparam logic [digits-1:0] BLANK_RST = ~digits'(1);

    logic [1:0]        state_q, state_d;
    logic [w-1:0]      shift_q, shift_d;
    logic [SW-1:0]     scratch_q, scratch_d;
    logic              ovf_q, ovf_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     bcd_q, bcd_d;
    logic [digits-1:0] blank_q, blank_d;
    logic              overflow_q, overflow_d;

    logic [SW-1:0]     adj;
    logic [SW+w-1:0]   cat;
    logic [SW-1:0]     scratch_nx;
    logic [w-1:0]      shift_nx;
    logic              ovf_nx;
    logic [digits-1:0] blank_nx;
    logic              zrun;

    for (genvar g = 0; g < digits; g++) begin : g_adj
        bcd_adjust u_adj (
            .nib_i (scratch_q[4*g +: 4]),
            .nib_o (adj[4*g +: 4])
        );
    end

    // Top bit of the adjusted scratch falls off; it only matters as overflow.
    assign cat        = {adj[SW-2:0], shift_q, 1'b0};
    assign scratch_nx = cat[SW+w-1 -: SW];
    assign shift_nx   = cat[w-1:0];
    assign ovf_nx     = ovf_q | adj[SW-1];

    always_comb begin
        zrun     = 1'b1;
        blank_nx = '0;
        for (int i = digits - 1; i >= 0; i--) begin
            zrun        = zrun & (scratch_nx[4*i +: 4] == 4'd0);
            blank_nx[i] = zrun & (i > 0);
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        blank_d    = blank_q;
        overflow_d = overflow_q;
        unique case (1'b1)
            (state_q == SHIFT): begin
                shift_d   = shift_nx;
                scratch_d = scratch_nx;
                ovf_d     = ovf_nx;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    bcd_d      = scratch_nx;
                    blank_d    = blank_nx;
                    overflow_d = OVF_POSSIBLE ? ovf_nx : 1'b0;
                    state_d    = DONE;
                end
            end
            (state_q == IDLE || state_q == DONE): begin
                if (bus.start) begin
                    shift_d   = bus.bin;
                    scratch_d = '0;
                    ovf_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end else begin
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            blank_q    <= BLANK_RST;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            blank_q    <= blank_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.busy     = (state_q == SHIFT);
    assign bus.done     = (state_q == DONE);
    assign bus.bcd      = bcd_q;
    assign bus.blank    = blank_q;
    assign bus.overflow = overflow_q;

endmodule
